// File: rtl/timer_dev_pkg.sv
// Register map, CTRL field positions, mode codes and FSM state encoding shared
// by the timer and the CPU/bridge side that programs it.
package timer_dev_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // Only 01 reloads; 00 and both 1x codes run as one-shot.
  localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  function automatic logic isAutoReload(input logic [1:0] mode);
    return (mode == MODE_AUTO_RELOAD);
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped programmable down-counter timer: CTRL/PRESET/COUNT window with
// one-shot (held interrupt) and auto-reload (one-cycle pulse) modes.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              irq
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   preset_q, preset_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                irqFlag_q, irqFlag_d;

  logic                ctrlEn;
  logic                ctrlIm;
  logic [1:0]          ctrlMode;
  logic                ctrlWrite;
  logic                presetWrite;

  logic                hwLoad;
  logic                hwDec;
  logic                hwExpire;
  logic                hwClrEn;
  logic                hwClrFlag;

  assign ctrlEn      = ctrl_q[CTRL_EN_BIT];
  assign ctrlIm      = ctrl_q[CTRL_IM_BIT];
  assign ctrlMode    = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign ctrlWrite   = we && (addr == ADDR_CTRL);
  assign presetWrite = we && (addr == ADDR_PRESET);

  // Sequencing uses the registered CTRL value, so a mode change made while
  // counting is only seen once the count expires.
  always_comb begin
    state_d   = state_q;
    hwLoad    = 1'b0;
    hwDec     = 1'b0;
    hwExpire  = 1'b0;
    hwClrEn   = 1'b0;
    hwClrFlag = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrlEn) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        hwLoad  = 1'b1;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrlEn) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          hwDec = 1'b1;
        end else begin
          hwExpire = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        if (isAutoReload(ctrlMode)) begin
          hwClrFlag = 1'b1;
          state_d   = ST_LOAD;
        end else begin
          hwClrEn = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CPU writes are applied last so they override any same-cycle hardware
  // update to EN or the interrupt flag.
  always_comb begin
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    irqFlag_d = irqFlag_q;
    if (hwClrEn) begin
      ctrl_d[CTRL_EN_BIT] = 1'b0;
    end
    if (hwExpire) begin
      irqFlag_d = 1'b1;
    end
    if (hwClrFlag) begin
      irqFlag_d = 1'b0;
    end
    if (ctrlWrite) begin
      ctrl_d    = wd[CTRL_W-1:0];
      irqFlag_d = 1'b0;
    end
    if (presetWrite) begin
      preset_d  = wd;
      irqFlag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      preset_q  <= '0;
      irqFlag_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      irqFlag_q <= irqFlag_d;
    end
  end

  // Expiry forces zero, which also makes a PRESET of 0 time exactly like 1.
  always_comb begin
    count_d = count_q;
    if (hwLoad) begin
      count_d = preset_q;
    end else if (hwDec) begin
      count_d = count_q - 32'd1;
    end else if (hwExpire) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_CTRL:   rd = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: rd = preset_q;
      ADDR_COUNT:  rd = count_q;
      default:     rd = '0;
    endcase
  end

  assign irq = ctrlIm & irqFlag_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus randomized
// preset/mode/mask runs compared against a closed-form timeline model.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checkCount;
  int errorCount;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus cycle: inputs held across the rising edge, strobe dropped 1 after it.
  task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w;
    addr = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    we = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    we = 1'b0;
    addr = 2'd0;
    wd = '0;
    #7;
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      checkCount++;
      if (rd !== 32'h0) begin
        errorCount++;
        $display("[TB] FAIL reset_rd addr%0d: got %h expected %h", a, rd, 32'h0);
      end
    end
    checkCount++;
    if (irq !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1, 2'd2, 32'h1234);
    addr = 2'd2;
    #1;
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL count_write_ignored: got %h expected %h", rd, 32'h0);
    end
    tick(1'b1, 2'd3, 32'hdeadbeef);
    #1;
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL addr3_read: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_registers();
    logic [3:0]  expCtrl;
    logic [31:0] expPreset;
    logic [1:0]  a;
    logic [31:0] d;
    applyReset();
    expCtrl = 4'h0;
    expPreset = 32'h0;
    for (int i = 0; i < 12; i++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom();
      if (a == 2'd0) d[0] = 1'b0;
      tick(1'b1, a, d);
      if (a == 2'd0) expCtrl = d[3:0];
      if (a == 2'd1) expPreset = d;
      addr = 2'd0;
      #1;
      checkCount++;
      if (rd !== {28'h0, expCtrl}) begin
        errorCount++;
        $display("[TB] FAIL reg_ctrl i=%0d: got %h expected %h", i, rd, {28'h0, expCtrl});
      end
      addr = 2'd1;
      #1;
      checkCount++;
      if (rd !== expPreset) begin
        errorCount++;
        $display("[TB] FAIL reg_preset i=%0d: got %h expected %h", i, rd, expPreset);
      end
      addr = 2'd2;
      #1;
      checkCount++;
      if (rd !== 32'h0) begin
        errorCount++;
        $display("[TB] FAIL reg_count i=%0d: got %h expected %h", i, rd, 32'h0);
      end
    end
  endtask

  task automatic test_one_shot();
    int unsigned expCount;
    logic expIrq;
    logic [31:0] expCtrl;
    applyReset();
    tick(1'b1, 2'd1, 32'd5);
    tick(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      expCount = (k >= 2 && k <= 6) ? 32'(7 - k) : 0;
      expIrq = (k >= 7);
      expCtrl = (k >= 8) ? 32'h8 : 32'h9;
      checkCount++;
      if (rd !== expCount || irq !== expIrq) begin
        errorCount++;
        $display("[TB] FAIL oneshot_count_irq k=%0d: got %0d/%b expected %0d/%b", k, rd, irq, expCount, expIrq);
      end
      addr = 2'd0;
      #1;
      checkCount++;
      if (rd !== expCtrl) begin
        errorCount++;
        $display("[TB] FAIL oneshot_ctrl k=%0d: got %h expected %h", k, rd, expCtrl);
      end
    end
    tick(1'b1, 2'd0, 32'h8);
    checkCount++;
    if (irq !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL oneshot_ack: got %b expected 0", irq);
    end
  endtask

  task automatic test_auto_reload();
    int unsigned pattern [5] = '{3, 2, 1, 0, 0};
    int unsigned expCount;
    logic expIrq;
    int pulses;
    applyReset();
    pulses = 0;
    tick(1'b1, 2'd1, 32'd3);
    tick(1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      expCount = (k < 2) ? 0 : pattern[(k - 2) % 5];
      expIrq = (k >= 5) && ((k % 5) == 0);
      if (irq === 1'b1) pulses++;
      checkCount++;
      if (rd !== expCount || irq !== expIrq) begin
        errorCount++;
        $display("[TB] FAIL auto_count_irq k=%0d: got %0d/%b expected %0d/%b", k, rd, irq, expCount, expIrq);
      end
    end
    checkCount++;
    if (pulses != 4) begin
      errorCount++;
      $display("[TB] FAIL auto_pulses: got %0d expected 4", pulses);
    end
  endtask

  task automatic test_mask_disable();
    int unsigned expCount;
    logic [31:0] expCtrl;
    applyReset();
    tick(1'b1, 2'd1, 32'd2);
    tick(1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      expCount = (k == 2) ? 2 : ((k == 3) ? 1 : 0);
      expCtrl = (k >= 5) ? 32'h0 : 32'h1;
      checkCount++;
      if (rd !== expCount || irq !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL masked_count_irq k=%0d: got %0d/%b expected %0d/0", k, rd, irq, expCount);
      end
      addr = 2'd0;
      #1;
      checkCount++;
      if (rd !== expCtrl) begin
        errorCount++;
        $display("[TB] FAIL masked_ctrl k=%0d: got %h expected %h", k, rd, expCtrl);
      end
    end

    applyReset();
    tick(1'b1, 2'd1, 32'd20);
    tick(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) tick(1'b0, 2'd2, 32'h0);
    checkCount++;
    if (rd !== 32'd16) begin
      errorCount++;
      $display("[TB] FAIL disable_precount: got %0d expected 16", rd);
    end
    tick(1'b1, 2'd0, 32'h8);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      checkCount++;
      if (rd !== 32'd15 || irq !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL disable_freeze k=%0d: got %0d/%b expected 15/0", k, rd, irq);
      end
    end
    tick(1'b1, 2'd0, 32'h9);
    tick(1'b0, 2'd2, 32'h0);
    tick(1'b0, 2'd2, 32'h0);
    checkCount++;
    if (rd !== 32'd20) begin
      errorCount++;
      $display("[TB] FAIL disable_reload: got %0d expected 20", rd);
    end
  endtask

  task automatic test_collision();
    int unsigned expCount [6] = '{0, 3, 2, 1, 0, 0};
    logic expIrq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    applyReset();
    tick(1'b1, 2'd1, 32'd3);
    tick(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) tick(1'b0, 2'd2, 32'h0);
    checkCount++;
    if (rd !== 32'd0 || irq !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL collision_int: got %0d/%b expected 0/1", rd, irq);
    end
    tick(1'b1, 2'd0, 32'hB);
    checkCount++;
    if (rd !== 32'hB || irq !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL collision_write_wins: got %h/%b expected %h/0", rd, irq, 32'hB);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 2'd2, 32'h0);
      checkCount++;
      if (rd !== expCount[i] || irq !== expIrq[i]) begin
        errorCount++;
        $display("[TB] FAIL collision_reload i=%0d: got %0d/%b expected %0d/%b", i, rd, irq, expCount[i], expIrq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    tick(1'b1, 2'd1, 32'd100);
    tick(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 62; k++) tick(1'b0, 2'd2, 32'h0);
    checkCount++;
    if (rd !== 32'd40) begin
      errorCount++;
      $display("[TB] FAIL areset_precount: got %0d expected 40", rd);
    end
    #1;
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      addr = a[1:0];
      #1;
      checkCount++;
      if (rd !== 32'h0 || irq !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL areset_immediate addr%0d: got %h/%b expected 0/0", a, rd, irq);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 110; k++) begin
      tick(1'b0, 2'd2, 32'h0);
      checkCount++;
      if (rd !== 32'h0 || irq !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL areset_quiet k=%0d: got %0d/%b expected 0/0", k, rd, irq);
      end
    end
  endtask

  // Model: cycle k after the enabling write; counting starts at k=2 and each
  // period is max(N,1)+2 cycles (N..1 counting, INT, LOAD).
  task automatic test_random_timeline();
    int unsigned n, nEff, j, p, ec, last;
    logic [1:0] mode;
    logic im, auto, ei, ee;
    for (int run = 0; run < 8; run++) begin
      n = $urandom_range(0, 10);
      mode = 2'($urandom_range(0, 3));
      im = 1'($urandom_range(0, 1));
      auto = (mode == 2'b01);
      nEff = (n == 0) ? 1 : n;
      last = auto ? 3 * (nEff + 2) + 2 : nEff + 6;
      applyReset();
      tick(1'b1, 2'd1, n);
      tick(1'b1, 2'd0, {28'h0, im, mode, 1'b1});
      for (int k = 1; k <= int'(last); k++) begin
        tick(1'b0, 2'd2, 32'h0);
        ec = 0;
        ei = 1'b0;
        ee = 1'b1;
        if (k >= 2) begin
          j = k - 2;
          if (!auto) begin
            if (j < nEff) begin
              ec = (j == 0) ? n : n - j;
            end else begin
              ei = im;
              ee = (j == nEff);
            end
          end else begin
            p = j % (nEff + 2);
            if (p < nEff) ec = (p == 0) ? n : n - p;
            ei = im && (p == nEff);
          end
        end
        checkCount++;
        if (rd !== ec || irq !== ei) begin
          errorCount++;
          $display("[TB] FAIL rand_count_irq run=%0d n=%0d mode=%0d im=%0d k=%0d: got %0d/%b expected %0d/%b",
                   run, n, mode, im, k, rd, irq, ec, ei);
        end
        addr = 2'd0;
        #1;
        checkCount++;
        if (rd !== {28'h0, im, mode, ee}) begin
          errorCount++;
          $display("[TB] FAIL rand_ctrl run=%0d k=%0d: got %h expected %h", run, k, rd, {28'h0, im, mode, ee});
        end
      end
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    test_reset();
    test_registers();
    test_one_shot();
    test_auto_reload();
    test_mask_disable();
    test_collision();
    test_async_reset();
    test_random_timeline();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped programmable down-counter timer on the processor bus, acting as the responder the CPU addresses through its PrAddr/PrWD/PrWe/PrRD bridge path. It occupies one 12-byte window (word offsets 0–2) and drives one hardware-interrupt line back into the CPU's HWInt vector. Two modes: one-shot, where the interrupt is held until software acknowledges it, and auto-reload, where the interrupt is a one-cycle pulse per period.

## Interface
- No parameters; base-address decode lives in the bridge.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; low forces all state to reset values immediately
- addr  input  2  word offset within window (bridge passes PrAddr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped
- we  input  1  write strobe, already gated by bridge decode and by CPU interrupt suppression
- wd  input  32  write data (PrWD)
- rd  output  32  read data, combinational from addr
- irq  output  1  interrupt request to one HWInt bit

## Operation
- CTRL[3:0]: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x behave as 00), bit3 IM (interrupt mask, 1=enabled). CTRL[31:4] read as 0, write ignored.
- PRESET[31:0]: reload value, read/write.
- COUNT[31:0]: current count, read-only; writes ignored.
- addr 3: reads 0, writes ignored.
- Write to CTRL or PRESET clears irq_flag.
- irq = IM & irq_flag.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE, COUNT holds. Else COUNT>1: COUNT<=COUNT-1, stay. Else (COUNT is 0 or 1): COUNT<=0, irq_flag<=1 -> INT.
  - INT, one-shot: EN<=0 -> IDLE; irq_flag stays set.
  - INT, auto-reload: irq_flag<=0 -> LOAD.
- Simultaneous events:
  - A CPU write in the same cycle as a hardware update to EN or irq_flag wins: written CTRL value stands, and irq_flag ends 0.
  - Writing PRESET while in CNT does not affect COUNT until the next LOAD.
  - Writing MODE while in CNT takes effect at INT.
- COUNT arithmetic: unsigned 32-bit; never decrements below 0, no wrap.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, irq=0, rd=0 for every addr.
- rd has zero latency (combinational); a write is visible on rd the cycle after its edge.
- Sequence from the edge E0 that writes EN=1 with PRESET=N≥1, state IDLE:
  - E1: LOAD
  - E2: COUNT=N
  - E(k+2): COUNT=N-k
  - E(N+2): COUNT=0, state INT, irq_flag=1
  - E(N+3): one-shot -> EN=0, IDLE, irq held; auto-reload -> irq_flag=0, LOAD
  - auto-reload: E(N+4) COUNT=N again; irq period N+2 cycles, pulse width 1 cycle.
- PRESET=0 times exactly like PRESET=1.
- reset low at any time (mid-count, in INT): state returns to reset values asynchronously; counting resumes only after software rewrites EN.

## Structure
- Register offsets, CTRL bit positions, MODE codes and FSM state encodings go in the shared macro header used by the CPU/bridge.
- Single module; no sub-module is natural. Counter, register file and FSM are small enough to keep in one always block per concern.

## Test plan
- Reset: hold reset low, then release -> rd=0 at addr 0/1/2, irq=0; write addr 2 with 0x1234 -> COUNT still reads 0.
- One-shot: PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1 on E2–E6; irq=1 from E7, held; CTRL reads 0x8 after E8; write CTRL=0x8 -> irq=0 next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> irq one-cycle pulses every 5 cycles for ≥4 periods; COUNT sequence 3,2,1,0 repeating.
- Mask and disable: CTRL=0x1 with PRESET=2 -> irq stays 0 while the internal flag sets. Clear EN mid-count -> COUNT freezes, state IDLE, no irq.
- Collision: CPU writes CTRL=0xB in the same cycle as one-shot INT -> EN remains 1, irq_flag=0, reload occurs.
- Async reset mid-count: PRESET=100, assert reset at COUNT=40 between edges -> all outputs 0 immediately, no irq after release.
